// File: rtl/stepper_phase_decoder_if.sv
// Stepper phase decoder bus: the tapped drive pattern and clear request going in,
// and the decoded position and status coming out.
//   stepmotor  : observed 4-bit full-step phase pattern
//   clr        : synchronous clear of position, fault and lock
//   position   : signed step count (POS_W bits, two's complement)
//   step_pulse : one-cycle strobe per decoded step
//   dir        : direction of last step (1 = right, 0 = left)
//   moving     : a step occurred recently
//   fault      : sticky illegal-sequence flag
//   state      : LED status code
// master drives stepmotor/clr (observer side); slave is the decoder.
interface stepper_phase_decoder_if #(
    parameter int unsigned POS_W = 16
);
    logic [3:0]       stepmotor;
    logic             clr;
    logic [POS_W-1:0] position;
    logic             step_pulse;
    logic             dir;
    logic             moving;
    logic             fault;
    logic [1:0]       state;

    modport master (
        output stepmotor, clr,
        input  position, step_pulse, dir, moving, fault, state
    );

    modport slave (
        input  stepmotor, clr,
        output position, step_pulse, dir, moving, fault, state
    );
endinterface

// File: rtl/stepper_phase_decoder.sv
// Passive monitor for the 4-bit full-step motor drive bus. Decodes the phase
// sequence into direction, a wrapping signed position, a motion indicator and a
// sticky fault for illegal or skipped phases.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : stepper_phase_decoder_if.slave (stepmotor, clr in; position,
//         step_pulse, dir, moving, fault, state out; all outputs registered)
// Build option: define STEPPER_DEC_SYNC_EN to pass stepmotor through a 2-flop
// synchronizer (decode latency grows from 1 to 3 cycles).
module stepper_phase_decoder #(
    parameter int unsigned POS_W        = 16,
    parameter int unsigned STALL_CYCLES = 1000
) (
    input logic                   clk,
    input logic                   rst,
    stepper_phase_decoder_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(STALL_CYCLES + 1);
    localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(STALL_CYCLES);

    localparam logic [1:0] LED_LEFT  = 2'b00;
    localparam logic [1:0] LED_IDLE  = 2'b01;
    localparam logic [1:0] LED_FAULT = 2'b10;
    localparam logic [1:0] LED_RIGHT = 2'b11;

    typedef enum logic [1:0] {
        S_UNLOCK = 2'd0,
        S_TRACK  = 2'd1,
        S_FAULT  = 2'd2
    } fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [1:0]       last_idx_q, last_idx_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             step_q, step_d;
    logic             dir_q, dir_d;
    logic             moving_q, moving_d;
    logic             fault_q, fault_d;
    logic [1:0]       led_q, led_d;
    logic             stepped_q, stepped_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [3:0]       pattern;
    logic             cur_valid;
    logic [1:0]       cur_idx;
    logic             idle;
    logic [1:0]       delta;

    // Input capture: optional two-flop synchronizer for an asynchronous driver
`ifdef STEPPER_DEC_SYNC_EN
    logic [3:0] sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 4'b0000;
            sync2_q <= 4'b0000;
        end else begin
            sync1_q <= bus.stepmotor;
            sync2_q <= sync1_q;
        end
    end

    assign pattern = sync2_q;
`else
    assign pattern = bus.stepmotor;
`endif

    // Phase pattern to index; anything but the four full-step codes is invalid
    always_comb begin
        cur_valid = 1'b1;
        cur_idx   = 2'd0;
        case (pattern)
            4'b1010: cur_idx = 2'd0;
            4'b0110: cur_idx = 2'd1;
            4'b0101: cur_idx = 2'd2;
            4'b1001: cur_idx = 2'd3;
            default: cur_valid = 1'b0;
        endcase
    end

    assign idle  = (pattern == 4'b0000);
    // Modulo-4 distance from the last phase: 1 = right, 3 = left, 2 = skipped
    assign delta = cur_idx - last_idx_q;

    // Next-state and registered-output logic
    always_comb begin
        fsm_d      = fsm_q;
        last_idx_d = last_idx_q;
        pos_d      = pos_q;
        step_d     = 1'b0;
        dir_d      = dir_q;
        fault_d    = fault_q;
        led_d      = led_q;
        stepped_d  = stepped_q;
        cnt_d      = cnt_q;
        moving_d   = 1'b0;

        case (fsm_q)
            S_UNLOCK: begin
                if (cur_valid) begin
                    last_idx_d = cur_idx;
                    fsm_d      = S_TRACK;
                    led_d      = LED_IDLE;
                end else if (!idle) begin
                    fsm_d   = S_FAULT;
                    fault_d = 1'b1;
                    led_d   = LED_FAULT;
                end
            end
            S_TRACK: begin
                if (cur_valid) begin
                    case (delta)
                        2'd1: begin
                            pos_d      = pos_q + POS_W'(1);
                            dir_d      = 1'b1;
                            step_d     = 1'b1;
                            led_d      = LED_RIGHT;
                            stepped_d  = 1'b1;
                            last_idx_d = cur_idx;
                        end
                        2'd3: begin
                            pos_d      = pos_q - POS_W'(1);
                            dir_d      = 1'b0;
                            step_d     = 1'b1;
                            led_d      = LED_LEFT;
                            stepped_d  = 1'b1;
                            last_idx_d = cur_idx;
                        end
                        2'd2: begin
                            fsm_d   = S_FAULT;
                            fault_d = 1'b1;
                            led_d   = LED_FAULT;
                        end
                        default: ;
                    endcase
                end else if (!idle) begin
                    fsm_d   = S_FAULT;
                    fault_d = 1'b1;
                    led_d   = LED_FAULT;
                end
            end
            S_FAULT: ;
            default: fsm_d = S_UNLOCK;
        endcase

        // Stall counter restarts on a step and saturates at the threshold
        if (step_d) begin
            cnt_d = '0;
        end else if (cnt_q < STALL_CNT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Clear overrides decode: a coincident step is discarded
        if (bus.clr) begin
            fsm_d      = S_UNLOCK;
            last_idx_d = 2'd0;
            pos_d      = '0;
            step_d     = 1'b0;
            dir_d      = 1'b0;
            fault_d    = 1'b0;
            led_d      = LED_IDLE;
            stepped_d  = 1'b0;
            cnt_d      = STALL_CNT;
        end

        moving_d = stepped_d && (cnt_d < STALL_CNT);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q      <= S_UNLOCK;
            last_idx_q <= 2'd0;
            pos_q      <= '0;
            step_q     <= 1'b0;
            dir_q      <= 1'b0;
            moving_q   <= 1'b0;
            fault_q    <= 1'b0;
            led_q      <= LED_IDLE;
            stepped_q  <= 1'b0;
            cnt_q      <= STALL_CNT;
        end else begin
            fsm_q      <= fsm_d;
            last_idx_q <= last_idx_d;
            pos_q      <= pos_d;
            step_q     <= step_d;
            dir_q      <= dir_d;
            moving_q   <= moving_d;
            fault_q    <= fault_d;
            led_q      <= led_d;
            stepped_q  <= stepped_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.position   = pos_q;
    assign bus.step_pulse = step_q;
    assign bus.dir        = dir_q;
    assign bus.moving     = moving_q;
    assign bus.fault      = fault_q;
    assign bus.state      = led_q;

endmodule

// File: tb/tb_stepper_phase_decoder.sv
// Directed bench for stepper_phase_decoder (POS_W=4, STALL_CYCLES=8).
module tb_stepper_phase_decoder;

`ifdef STEPPER_DEC_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    stepper_phase_decoder_if #(.POS_W(4)) bus ();

    stepper_phase_decoder #(
        .POS_W       (4),
        .STALL_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a pattern and hold it until its decode is visible
    task automatic apply(input logic [3:0] p);
        bus.stepmotor = p;
        repeat (LAT) tick();
    endtask

    // Clear with a new pattern, held long enough to flush any synchronizer
    task automatic clear_with(input logic [3:0] p);
        bus.stepmotor = p;
        bus.clr = 1'b1;
        repeat (LAT) tick();
        bus.clr = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] pos, input logic sp,
                              input logic d, input logic [1:0] st, input logic f);
        check({tag, ".position"},   32'(bus.position),   32'(pos));
        check({tag, ".step_pulse"}, 32'(bus.step_pulse), 32'(sp));
        check({tag, ".dir"},        32'(bus.dir),        32'(d));
        check({tag, ".state"},      32'(bus.state),      32'(st));
        check({tag, ".fault"},      32'(bus.fault),      32'(f));
    endtask

    initial begin
        logic [3:0] phases [4];
        int ph;
        int n;
        phases[0] = 4'b1010;
        phases[1] = 4'b0110;
        phases[2] = 4'b0101;
        phases[3] = 4'b1001;
        checks = 0;
        errors = 0;

        rst = 1'b1;
        bus.clr = 1'b0;
        bus.stepmotor = 4'b0000;
        repeat (3) tick();
        expect_out("reset", 4'd0, 1'b0, 1'b0, 2'b01, 1'b0);
        check("reset.moving", 32'(bus.moving), 32'd0);
        rst = 1'b0;

        // Lock, then four right steps
        apply(4'b1010);
        expect_out("lock", 4'd0, 1'b0, 1'b0, 2'b01, 1'b0);
        check("lock.moving", 32'(bus.moving), 32'd0);
        apply(4'b0110);
        expect_out("r1", 4'd1, 1'b1, 1'b1, 2'b11, 1'b0);
        tick();
        check("pulse_width", 32'(bus.step_pulse), 32'd0);
        apply(4'b0101);
        expect_out("r2", 4'd2, 1'b1, 1'b1, 2'b11, 1'b0);
        apply(4'b1001);
        expect_out("r3", 4'd3, 1'b1, 1'b1, 2'b11, 1'b0);
        apply(4'b1010);
        expect_out("r4", 4'd4, 1'b1, 1'b1, 2'b11, 1'b0);

        // Four left steps back to zero
        apply(4'b1001);
        expect_out("l1", 4'd3, 1'b1, 1'b0, 2'b00, 1'b0);
        apply(4'b0101);
        expect_out("l2", 4'd2, 1'b1, 1'b0, 2'b00, 1'b0);
        apply(4'b0110);
        expect_out("l3", 4'd1, 1'b1, 1'b0, 2'b00, 1'b0);
        apply(4'b1010);
        expect_out("l4", 4'd0, 1'b1, 1'b0, 2'b00, 1'b0);

        // Seven right steps to +7, then one more wraps to -8
        ph = 0;
        for (int k = 0; k < 7; k++) begin
            ph = (ph + 1) % 4;
            apply(phases[ph]);
        end
        expect_out("to7", 4'd7, 1'b1, 1'b1, 2'b11, 1'b0);
        ph = (ph + 1) % 4;
        apply(phases[ph]);
        expect_out("wrap_pos", 4'd8, 1'b1, 1'b1, 2'b11, 1'b0);

        // moving high for 8 cycles after the step, then low
        check("stall.t0", 32'(bus.moving), 32'd1);
        for (int k = 1; k < 8; k++) begin
            tick();
            check($sformatf("stall.t%0d", k), 32'(bus.moving), 32'd1);
        end
        tick();
        check("stall.t8", 32'(bus.moving), 32'd0);
        expect_out("stall_hold", 4'd8, 1'b0, 1'b1, 2'b11, 1'b0);

        // Idle gap of five cycles, then the next phase is exactly one step
        for (int k = 0; k < 5; k++) apply(4'b0000);
        expect_out("idle", 4'd8, 1'b0, 1'b1, 2'b11, 1'b0);
        apply(4'b0110);
        expect_out("after_idle", 4'd9, 1'b1, 1'b1, 2'b11, 1'b0);
        tick();
        expect_out("after_idle2", 4'd9, 1'b0, 1'b1, 2'b11, 1'b0);

        // Skipped phase faults; later steps ignored; clr recovers
        apply(4'b1010);
        expect_out("back", 4'd8, 1'b1, 1'b0, 2'b00, 1'b0);
        apply(4'b0101);
        expect_out("skip", 4'd8, 1'b0, 1'b0, 2'b10, 1'b1);
        apply(4'b1001);
        expect_out("ignored", 4'd8, 1'b0, 1'b0, 2'b10, 1'b1);
        clear_with(4'b1001);
        expect_out("clr", 4'd0, 1'b0, 1'b0, 2'b01, 1'b0);
        check("clr.moving", 32'(bus.moving), 32'd0);

        // Relock on 1001, one left step wraps to -1
        apply(4'b1001);
        expect_out("relock", 4'd0, 1'b0, 1'b0, 2'b01, 1'b0);
        apply(4'b0101);
        expect_out("wrap_neg", 4'd15, 1'b1, 1'b0, 2'b00, 1'b0);

        // Illegal pattern after lock
        apply(4'b1111);
        expect_out("illegal", 4'd15, 1'b0, 1'b0, 2'b10, 1'b1);
        clear_with(4'b1010);
        apply(4'b1010);
        expect_out("relock2", 4'd0, 1'b0, 1'b0, 2'b01, 1'b0);
        apply(4'b0110);
        expect_out("pre_rst", 4'd1, 1'b1, 1'b1, 2'b11, 1'b0);

        // rst with a coincident step
        bus.stepmotor = 4'b0101;
        rst = 1'b1;
        tick();
        expect_out("rst_step", 4'd0, 1'b0, 1'b0, 2'b01, 1'b0);
        check("rst_step.moving", 32'(bus.moving), 32'd0);
        repeat (LAT - 1) tick();
        rst = 1'b0;
        apply(4'b0101);
        apply(4'b1001);
        expect_out("pre_clr", 4'd1, 1'b1, 1'b1, 2'b11, 1'b0);

        // clr with a coincident step
        bus.stepmotor = 4'b1010;
        bus.clr = 1'b1;
        tick();
        expect_out("clr_step", 4'd0, 1'b0, 1'b0, 2'b01, 1'b0);
        check("clr_step.moving", 32'(bus.moving), 32'd0);
        repeat (LAT - 1) tick();
        bus.clr = 1'b0;

        // Decode latency from pattern change to step_pulse
        apply(4'b1010);
        expect_out("lat_lock", 4'd0, 1'b0, 1'b0, 2'b01, 1'b0);
        bus.stepmotor = 4'b0110;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.step_pulse && n < 10);
        check("latency", 32'(n), 32'(LAT));
        check("latency.position", 32'(bus.position), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stepper_phase_decoder.md
# stepper_phase_decoder

- Passive monitor on the 4-bit full-step motor drive bus produced by `stepper_control`.
- Decodes the phase pattern to recover rotation direction, a signed step position, a motion indicator and a sticky fault flag for illegal or skipped phases.
- Sits beside the motor driver, tapping `stepmotor`, and feeds position and status back to the board LEDs and higher-level control.

## Interface
- `POS_W`, 16: width of the two's-complement position counter.
- `STALL_CYCLES`, 1000: clock cycles without a step before `moving` deasserts (≥1, counter sized by `$clog2(STALL_CYCLES+1)`).

- `clk` input 1: system clock; all logic rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `stepmotor` input 4: observed phase pattern from the driver.
- `clr` input 1: synchronous clear of position, fault and lock; one-cycle pulse or level.
- `position` output POS_W: signed step count, +1 per right step, −1 per left step.
- `step_pulse` output 1: one-cycle strobe for each decoded step.
- `dir` output 1: direction of last decoded step (1 = right, 0 = left).
- `moving` output 1: a step occurred within the last STALL_CYCLES cycles.
- `fault` output 1: sticky illegal-sequence flag.
- `state` output 2: LED status.
  - 11 = last step right.
  - 00 = last step left.
  - 01 = no step since lock.
  - 10 = fault.

## Operation
- Phase index map:
  - 1010 = 0
  - 0110 = 1
  - 0101 = 2
  - 1001 = 3
- 0000 = idle (driver held in reset): no step, last phase retained.
- Any other pattern is illegal.
- Index delta, modulo 4, between the current pattern and the stored last phase:
  - 0: no event.
  - +1: right step.
  - −1 (3): left step.
  - 2: skipped phase, treated as a fault.
- FSM states:
  - UNLOCK:
    - A valid phase stores its index and goes to TRACK. No step, `state`=01.
    - 0000 stays in UNLOCK.
    - An illegal pattern goes to FAULT.
  - TRACK:
    - Right step: `position`+1, `dir`=1, `step_pulse`=1, `state`=11.
    - Left step: `position`−1, `dir`=0, `step_pulse`=1, `state`=00.
    - Delta 2 or illegal pattern: go to FAULT, `fault`=1, position unchanged.
    - 0000 stays in TRACK with no change.
  - FAULT:
    - `state`=10; all inputs ignored.
    - Exit only via `clr` or `rst`, both returning to UNLOCK.
- Position wraps modulo 2^POS_W: 0x7FFF+1 → 0x8000, 0x0000−1 → 0xFFFF.
- Stall counter:
  - Reset to 0 on every `step_pulse`; otherwise it increments, saturating at STALL_CYCLES.
  - `moving` = 1 while counter < STALL_CYCLES and at least one step has occurred since lock.
- Priority: `rst` > `clr` > decode. A step and `clr` in the same cycle are discarded, and position reads 0.
- Reset and `clr` values:
  - `position`=0, `step_pulse`=0, `dir`=0, `moving`=0, `fault`=0, `state`=01.
  - FSM=UNLOCK, stall counter=STALL_CYCLES.

## Timing
- All outputs are registered.
- Without the synchronizer, a pattern change sampled at edge N produces `step_pulse` and the updated `position`, `dir` and `state` after edge N. This is one cycle of latency.
- `fault` asserts on the same edge as the offending pattern's decode.
- `step_pulse` is exactly one cycle wide, even if the pattern holds for many cycles.
- Back-to-back steps on consecutive cycles are each counted, so throughput is one step per clock.
- `moving` falls exactly STALL_CYCLES cycles after the last `step_pulse` cycle.

## Configuration
- `STEPPER_DEC_SYNC_EN`:
  - Defined: `stepmotor` passes through a 2-flop synchronizer, and the decode latency becomes 3 cycles. The synchronizer flops reset to 0000.
  - Undefined: `stepmotor` is sampled directly (same-clock source), with 1-cycle latency.
- All other behaviour is identical in both builds.

## Test plan
1. Reset, then drive 1010, 0110, 0101, 1001, 1010 one pattern per cycle. Required response:
   - Lock on 1010.
   - 4 `step_pulse`s.
   - `position`=4, `dir`=1, `state`=11.
2. From TRACK at `position`=4, drive 1010, 1001, 0101, 0110, 1010. Required response: `position`=0, `dir`=0, `state`=00.
3. In TRACK at phase 1010, drive 0101 (skip). Required response:
   - `fault`=1, `state`=10, `position` unchanged.
   - Further valid steps are ignored.
   - After a `clr` pulse: `fault`=0, `position`=0, `state`=01.
4. Drive 1111 after lock. Required response: FAULT. Separately, drive 0000 for 5 cycles mid-sequence, then the next legal phase. Required response: exactly one step is counted, with no fault.
5. With STALL_CYCLES=8, take one right step and hold the pattern. Required response: `moving`=1 for 8 cycles, then 0. With POS_W=4 and `position`=7, one right step gives `position`=8 (−8).
6. Assert `rst` and a right step in the same cycle, then `clr` and a step in the same cycle. Required response: all outputs at their reset values, and `position`=0 after each. Repeat scenario 1 with `STEPPER_DEC_SYNC_EN` defined and confirm the first `step_pulse` arrives 2 cycles later.
